// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and capture FSM encoding
// for the UART receive-side buffer.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_ADDR_WIDTH = 4;

  typedef enum logic {
    CAP_WAIT = 1'b0,
    CAP_HOLD = 1'b1
  } cap_state_t;

  function automatic int fifoDepth(input int addrWidth);
    return 1 << addrWidth;
  endfunction

  localparam int UART_DEPTH = fifoDepth(UART_ADDR_WIDTH);

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: show-ahead byte stream, valid/ready.
// master: OutData/OutValid out, OutReady in.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] OutData;
  logic                  OutValid;
  logic                  OutReady;

  modport master (
    output OutData,
    output OutValid,
    input  OutReady
  );

  modport slave (
    input  OutData,
    input  OutValid,
    output OutReady
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: circular buffer with occupancy count.
// Ports: Clk, RxSamplerReset, PushReq/PushData,
// PopReq, HeadData (show-ahead), Count, Full, Empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  RxSamplerReset,
  input  logic                  PushReq,
  input  logic [DATA_WIDTH-1:0] PushData,
  input  logic                  PopReq,
  output logic [DATA_WIDTH-1:0] HeadData,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Full,
  output logic                  Empty
);

  localparam int DEPTH = fifoDepth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
    ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic                  doPush;
  logic                  doPop;

  assign Full     = (Count == DEPTH_CNT);
  assign Empty    = (Count == '0);
  // Full blocks a push even when a pop frees
  // a slot on the same edge.
  assign doPush   = PushReq && !Full;
  assign doPop    = PopReq && !Empty;
  assign HeadData = mem[rdPtr];

  always_ff @(posedge Clk) begin
    if (doPush) begin
      mem[wrPtr] <= PushData;
    end
  end

  always_ff @(posedge Clk or negedge RxSamplerReset) begin
    if (!RxSamplerReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      unique case ({doPush, doPop})
        2'b10:   Count <= Count + CNT_ONE;
        2'b01:   Count <= Count - CNT_ONE;
        default: Count <= Count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: acks receiver bytes into a buffer,
// serves them on OutIf, sticky LineError/Overflow.
// Ports: Clk, RxSamplerReset, UartRxData/Ready/Error,
// UartRxEnable, OutIf (master), Count, Overflow,
// LineError, ClearFlags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = UART_ADDR_WIDTH,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  RxSamplerReset,
  input  logic [DATA_WIDTH-1:0] UartRxData,
  input  logic                  UartRxReady,
  input  logic                  UartRxError,
  output logic                  UartRxEnable,
  uart_rx_fifo_if.master        OutIf,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  LineError,
  input  logic                  ClearFlags
);

  cap_state_t            capState;
  logic                  errQ;
  logic                  full;
  logic                  empty;
  logic                  capture;
  logic                  lineSet;
  logic                  ovfSet;
  logic [DATA_WIDTH-1:0] headData;

  assign capture = (capState == CAP_WAIT)
                && UartRxReady && !full;
  assign lineSet = UartRxError && !errQ;
  assign ovfSet  = UartRxError && full;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .Clk            (Clk),
    .RxSamplerReset (RxSamplerReset),
    .PushReq        (capture),
    .PushData       (UartRxData),
    .PopReq         (OutIf.OutReady),
    .HeadData       (headData),
    .Count          (Count),
    .Full           (full),
    .Empty          (empty)
  );

  assign OutIf.OutData  = headData;
  assign OutIf.OutValid = !empty;

  // HOLD waits for RxReady to drop so the byte the
  // receiver still shows after the ack is not taken
  // twice.
  always_ff @(posedge Clk or negedge RxSamplerReset) begin
    if (!RxSamplerReset) begin
      capState     <= CAP_WAIT;
      UartRxEnable <= 1'b0;
      errQ         <= 1'b0;
      LineError    <= 1'b0;
      Overflow     <= 1'b0;
    end else begin
      errQ <= UartRxError;
      unique case (capState)
        CAP_WAIT: begin
          UartRxEnable <= capture;
          if (capture) begin
            capState <= CAP_HOLD;
          end
        end
        CAP_HOLD: begin
          UartRxEnable <= 1'b0;
          if (!UartRxReady) begin
            capState <= CAP_WAIT;
          end
        end
      endcase
      // A set condition beats a same-cycle clear.
      priority case (1'b1)
        lineSet:    LineError <= 1'b1;
        ClearFlags: LineError <= 1'b0;
        default:    LineError <= LineError;
      endcase
      priority case (1'b1)
        ovfSet:     Overflow <= 1'b1;
        ClearFlags: Overflow <= 1'b0;
        default:    Overflow <= Overflow;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: receiver/consumer models around
// uart_rx_fifo with a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = UART_DEPTH;

  logic       Clk = 1'b0;
  logic       RxSamplerReset;
  logic       rxValid;
  logic [7:0] rxData;
  logic       UartRxError;
  logic       UartRxEnable;
  logic       ClearFlags;
  logic       Overflow;
  logic       LineError;
  logic [4:0] Count;

  uart_rx_fifo_if #(.DATA_WIDTH(8)) outIf ();

  uart_rx_fifo dut (
    .Clk            (Clk),
    .RxSamplerReset (RxSamplerReset),
    .UartRxData     (rxData),
    .UartRxReady    (rxValid),
    .UartRxError    (UartRxError),
    .UartRxEnable   (UartRxEnable),
    .OutIf          (outIf),
    .Count          (Count),
    .Overflow       (Overflow),
    .LineError      (LineError),
    .ClearFlags     (ClearFlags)
  );

  always #5 Clk = ~Clk;

  int   nCmp = 0;
  int   nBad = 0;
  logic [7:0] mq[$];
  logic [7:0] popLog[$];
  bit   logOn = 0;
  bit   mLine = 0;
  bit   mOvf = 0;
  bit   prevErr = 0;
  bit   rxAcked = 0;
  int   rxIdle = 1;
  int   mode = 0;

  typedef struct {
    bit err;
    bit clr;
    bit expLine;
    bit expOvf;
  } flagVec_t;

  flagVec_t vecs[7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // One clock edge: advance the reference model by
  // the buffer rules, compare, then move the
  // receiver and consumer models.
  task automatic step();
    int   pre;
    bit   expAck;
    logic [7:0] pb;
    @(posedge Clk);
    #1;
    if (!RxSamplerReset) return;
    pre    = mq.size();
    expAck = rxValid && !rxAcked && pre < DEPTH;
    chk("ack", UartRxEnable, expAck);
    if (pre > 0 && outIf.OutReady) begin
      pb = mq.pop_front();
      if (logOn) popLog.push_back(pb);
    end
    if (expAck) mq.push_back(rxData);
    if (UartRxError && !prevErr) mLine = 1;
    else if (ClearFlags) mLine = 0;
    if (UartRxError && pre == DEPTH) mOvf = 1;
    else if (ClearFlags) mOvf = 0;
    prevErr = UartRxError;
    chk("count", Count, mq.size());
    chk("valid", outIf.OutValid, mq.size() != 0);
    chk("line", LineError, mLine);
    chk("ovf", Overflow, mOvf);
    if (mq.size() > 0) chk("data", outIf.OutData, mq[0]);
    if (rxAcked) begin
      rxValid = 0;
      rxAcked = 0;
      rxIdle  = 0;
    end else if (expAck) begin
      rxAcked = 1;
    end else if (!rxValid) begin
      rxIdle++;
    end
    case (mode)
      1: outIf.OutReady = !outIf.OutReady;
      2: outIf.OutReady = ($urandom_range(0, 3) == 0);
      default: ;
    endcase
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    while ((rxValid || rxIdle < 1) && n < 500) begin
      step();
      n++;
    end
    chk("sendWait", rxValid, 0);
    rxData  = b;
    rxValid = 1;
  endtask

  task automatic waitDrained();
    int n = 0;
    while (rxValid && n < 500) begin
      step();
      n++;
    end
    chk("drainWait", rxValid, 0);
  endtask

  task automatic emptyBuf();
    int n = 0;
    outIf.OutReady = 1;
    while ((mq.size() > 0 || rxValid) && n < 200) begin
      step();
      n++;
    end
    outIf.OutReady = 0;
    chk("emptyWait", Count, 0);
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 0};
    vecs[2] = '{1, 1, 0, 0};
    vecs[3] = '{1, 0, 0, 0};
    vecs[4] = '{0, 0, 0, 0};
    vecs[5] = '{1, 1, 1, 0};
    vecs[6] = '{0, 1, 0, 0};

    RxSamplerReset = 0;
    rxValid        = 0;
    rxData         = '0;
    UartRxError    = 0;
    ClearFlags     = 0;
    outIf.OutReady = 0;
    #12;
    chk("rstCount", Count, 0);
    chk("rstValid", outIf.OutValid, 0);
    chk("rstEnable", UartRxEnable, 0);
    chk("rstOvf", Overflow, 0);
    chk("rstLine", LineError, 0);
    @(posedge Clk);
    #1;
    RxSamplerReset = 1;

    // single byte
    sendByte(8'hA5);
    step();
    chk("sbEnable", UartRxEnable, 1);
    chk("sbValid", outIf.OutValid, 1);
    chk("sbData", outIf.OutData, 8'hA5);
    chk("sbCount", Count, 1);
    step();
    chk("sbPulse", UartRxEnable, 0);
    outIf.OutReady = 1;
    step();
    outIf.OutReady = 0;
    chk("sbPopCount", Count, 0);
    chk("sbPopValid", outIf.OutValid, 0);

    // fill and backpressure
    for (int i = 0; i < 16; i++) sendByte(8'(i));
    waitDrained();
    chk("fillCount", Count, 16);
    sendByte(8'h10);
    repeat (4) step();
    chk("heldWhileFull", rxValid && !rxAcked, 1);
    chk("headFull", outIf.OutData, 8'h00);
    outIf.OutReady = 1;
    step();
    outIf.OutReady = 0;
    chk("popBlocksPush", Count, 15);
    step();
    chk("lateAck", UartRxEnable, 1);
    chk("refill", Count, 16);
    emptyBuf();

    // wrap-around with toggling consumer
    popLog.delete();
    logOn = 1;
    mode  = 1;
    for (int i = 0; i < 40; i++) sendByte(8'(8'h30 + i));
    waitDrained();
    for (int n = 0; n < 40 && mq.size() > 0; n++) step();
    mode  = 0;
    logOn = 0;
    outIf.OutReady = 0;
    chk("wrapLen", popLog.size(), 40);
    for (int i = 0; i < popLog.size(); i++)
      chk("wrapOrder", popLog[i], 8'(8'h30 + i));
    emptyBuf();

    // simultaneous push and pop at Count=5
    for (int i = 0; i < 5; i++) sendByte(8'(8'h60 + i));
    waitDrained();
    chk("simPre", Count, 5);
    sendByte(8'h77);
    outIf.OutReady = 1;
    step();
    outIf.OutReady = 0;
    chk("simCount", Count, 5);
    chk("simHead", outIf.OutData, 8'h61);
    waitDrained();
    outIf.OutReady = 1;
    repeat (4) step();
    outIf.OutReady = 0;
    chk("simTail", outIf.OutData, 8'h77);
    chk("simTailCnt", Count, 1);

    // error flags at Count=3
    sendByte(8'h78);
    sendByte(8'h79);
    waitDrained();
    chk("errPre", Count, 3);
    foreach (vecs[i]) begin
      UartRxError = vecs[i].err;
      ClearFlags  = vecs[i].clr;
      step();
      chk("vecLine", LineError, vecs[i].expLine);
      chk("vecOvf", Overflow, vecs[i].expOvf);
    end
    UartRxError = 0;
    ClearFlags  = 0;

    // overflow when full
    for (int i = 0; i < 13; i++) sendByte(8'(8'h80 + i));
    waitDrained();
    chk("ovfFull", Count, 16);
    UartRxError = 1;
    step();
    chk("ovfSet", Overflow, 1);
    chk("ovfLine", LineError, 1);
    ClearFlags = 1;
    step();
    chk("ovfSetWins", Overflow, 1);
    UartRxError = 0;
    step();
    ClearFlags = 0;
    chk("clrOvf", Overflow, 0);
    chk("clrLine", LineError, 0);
    emptyBuf();

    // reset while the FSM holds a handshake
    sendByte(8'h5A);
    step();
    chk("holdAck", UartRxEnable, 1);
    #2;
    RxSamplerReset = 0;
    #1;
    chk("midRstCount", Count, 0);
    chk("midRstEnable", UartRxEnable, 0);
    chk("midRstValid", outIf.OutValid, 0);
    mq.delete();
    mLine   = 0;
    mOvf    = 0;
    prevErr = 0;
    rxAcked = 0;
    repeat (2) step();
    RxSamplerReset = 1;
    step();
    chk("recapture", Count, 1);
    chk("recapData", outIf.OutData, 8'h5A);
    emptyBuf();

    // randomized traffic with slow consumer
    mode = 2;
    for (int i = 0; i < 150; i++) begin
      UartRxError = ($urandom_range(0, 7) == 0);
      ClearFlags  = ($urandom_range(0, 3) == 0);
      sendByte(8'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end
    UartRxError = 0;
    ClearFlags  = 0;
    mode = 0;
    emptyBuf();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer placed directly downstream of the UART receiver.
- Acknowledges each received byte via the receiver's RxReady/RxEnable handshake and stores it in a circular buffer.
- Presents bytes to the consumer over a valid/ready interface.
- Provides sticky line-error and overflow status.
- Lets the consumer absorb bursts without the receiver holding a byte and faulting on the next start bit.

Parameters:
ADDR_WIDTH, 4, log2 of buffer depth; DEPTH = 2**ADDR_WIDTH entries (16).
DATA_WIDTH, 8, byte width; must match the receiver data width.

Ports:
Clk  input  1  system clock, all logic on rising edge
RxSamplerReset  input  1  asynchronous, active-low reset
UartRxData  input  DATA_WIDTH  received byte from the receiver, valid while UartRxReady=1
UartRxReady  input  1  receiver holds a complete byte
UartRxError  input  1  receiver framing/overrun error (level, sticky in the receiver)
UartRxEnable  output  1  one-cycle acknowledge to the receiver
OutData  output  DATA_WIDTH  head-of-buffer byte (show-ahead)
OutValid  output  1  buffer non-empty
OutReady  input  1  consumer accepts OutData this cycle
Count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
Overflow  output  1  sticky: receiver error occurred while buffer full
LineError  output  1  sticky: rising edge seen on UartRxError
ClearFlags  input  1  synchronous clear of Overflow and LineError

Behaviour:
- Reset: clock is Clk; reset is RxSamplerReset, asynchronous, active-low.
  - Clears rd/wr pointers, Count=0, OutValid=0, UartRxEnable=0, Overflow=0, LineError=0, error-edge register=0, capture FSM=CAP_WAIT.
  - Buffer contents are not reset.
  - OutData is undefined while OutValid=0.
- Capture FSM states: CAP_WAIT, CAP_HOLD.
  - CAP_WAIT: on an edge sampling UartRxReady=1 and Count<DEPTH:
    - write UartRxData at wr_ptr;
    - wr_ptr+1 (wraps mod DEPTH);
    - UartRxEnable=1 for exactly the following cycle;
    - go to CAP_HOLD.
  - CAP_WAIT with UartRxReady=1 and Count==DEPTH: no write, UartRxEnable stays 0. The byte remains held in the receiver (backpressure).
  - CAP_HOLD: UartRxEnable=0. Return to CAP_WAIT on the first edge sampling UartRxReady=0. This guarantees one capture per byte even though the receiver drops RxReady one cycle after the acknowledge.
- Latency: byte is visible on OutData/OutValid the cycle after the capturing edge if the buffer was empty. Minimum 3 cycles between captures.
- Read side:
  - OutValid = (Count!=0).
  - OutData = mem[rd_ptr], combinational read.
  - Pop when OutValid && OutReady: rd_ptr+1, wraps mod DEPTH.
  - OutReady while empty is ignored.
- Simultaneous push and pop: Count unchanged, both pointers advance.
- Full case: push is blocked when Count==DEPTH even if a pop occurs the same cycle. The capture is taken on the next edge.
- Count width is ADDR_WIDTH+1 so full and empty are unambiguous. Pointers are ADDR_WIDTH wide and wrap naturally.
- Error flags:
  - LineError is set on an edge where UartRxError=1 and its registered value was 0.
  - Overflow is set on any edge where UartRxError=1 and Count==DEPTH.
  - ClearFlags=1 clears both; a set condition in the same cycle wins.
  - The block never clears the receiver's error; that requires the receiver's own reset.
- Reset mid-operation: the block restarts in CAP_WAIT. A byte still held by the receiver is captured again as a new byte. Buffered data is discarded.

Decomposition:
- Shared package uart_pkg:
  - capture FSM state encoding (CAP_WAIT=0, CAP_HOLD=1);
  - default DATA_WIDTH and ADDR_WIDTH;
  - DEPTH derivation constant.
- One sub-module: uart_sync_fifo (storage array, pointers, Count, push/pop with full/empty guards). The capture FSM and error flags stay in the top.

Test Plan:
- Single byte: UartRxData=0xA5 with UartRxReady high, OutReady=0 -> UartRxEnable one-cycle pulse; next cycle OutValid=1, OutData=0xA5, Count=1; OutReady=1 -> Count=0, OutValid=0.
- Fill: 16 bytes 0x00..0x0F, no reads -> Count=16. A 17th byte 0x10 gets no UartRxEnable while full. One pop (OutData=0x00) -> 0x10 acknowledged, Count returns to 16.
- Wrap-around order: 40 bytes 0x30..0x57 with OutReady toggling every other cycle -> read sequence exactly 0x30..0x57, no duplicates or losses.
- Simultaneous: at Count=5, push 0x77 and pop in the same cycle -> Count stays 5, head advances, 0x77 appears after 5 pops.
- Errors:
  - UartRxError rises with Count=3 -> LineError=1, Overflow=0.
  - Fill to 16, then raise UartRxError -> Overflow=1.
  - ClearFlags pulse with UartRxError low -> both 0.
- Reset in CAP_HOLD: assert RxSamplerReset low mid-handshake -> all outputs reset immediately (Count=0, UartRxEnable=0). After release with UartRxReady still 1 -> byte recaptured, Count=1.
